// File: rtl/dice_cgra_cfg_loader.sv
// Assembles a CGRA configuration vector from a valid/ready bitstream word stream.
// Define DICE_CFG_CHECKSUM_EN to expect a per-tile XOR checksum word after each tile's data.
module dice_cgra_cfg_loader #(
   parameter int unsigned TILE_BITS  = 156,
   parameter int unsigned NUM_TILES  = 16,
   parameter int unsigned WORD_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            abort,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WORD_WIDTH-1:0]           in_data,
   output logic [TILE_BITS*NUM_TILES-1:0]  cgra_cfg,
   output logic                            cfg_valid,
   output logic                            busy,
   output logic                            done,
   output logic                            cfg_err
);

   localparam int unsigned CFG_WIDTH = TILE_BITS * NUM_TILES;
   localparam int unsigned WPT       = (TILE_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int unsigned LAST_BITS = TILE_BITS - (WPT - 1) * WORD_WIDTH;
   localparam int unsigned WIDX_W    = (WPT > 1) ? $clog2(WPT) : 1;
   localparam int unsigned TIDX_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

`ifdef DICE_CFG_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

   state_t                 state_q, state_d;
   logic [WIDX_W-1:0]      word_idx_q, word_idx_d;
   logic [TIDX_W-1:0]      tile_idx_q, tile_idx_d;
   logic [TILE_BITS-1:0]   stage_q, stage_d;
   logic [CFG_WIDTH-1:0]   cfg_q, cfg_d;
   logic                   cfg_valid_q, cfg_valid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   in_ready_q, in_ready_d;
`ifdef DICE_CFG_CHECKSUM_EN
   logic                   err_q, err_d;
   logic [WORD_WIDTH-1:0]  ck_q, ck_d;
`endif

   logic                   accept;
   logic                   last_word;
   logic                   last_tile;
   logic                   commit_en;
   logic [TILE_BITS-1:0]   tile_full;

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d     = state_q;
      word_idx_d  = word_idx_q;
      tile_idx_d  = tile_idx_q;
      stage_d     = stage_q;
      cfg_d       = cfg_q;
      cfg_valid_d = cfg_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      commit_en   = 1'b0;
`ifdef DICE_CFG_CHECKSUM_EN
      err_d       = err_q;
      ck_d        = ck_q;
`endif
      accept      = in_valid && in_ready_q;
      last_word   = (word_idx_q == WIDX_W'(WPT - 1));
      last_tile   = (tile_idx_q == TIDX_W'(NUM_TILES - 1));
      // Final word contributes only its low LAST_BITS bits
      tile_full   = stage_q;
      tile_full[(WPT-1)*WORD_WIDTH +: LAST_BITS] = in_data[LAST_BITS-1:0];

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LOAD;
               word_idx_d  = '0;
               tile_idx_d  = '0;
               stage_d     = '0;
               cfg_d       = '0;
               cfg_valid_d = 1'b0;
               busy_d      = 1'b1;
`ifdef DICE_CFG_CHECKSUM_EN
               err_d       = 1'b0;
               ck_d        = '0;
`endif
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               stage_d = '0;
            end else if (accept) begin
               for (int unsigned k = 0; k < WPT - 1; k++) begin
                  if (word_idx_q == WIDX_W'(k)) stage_d[k*WORD_WIDTH +: WORD_WIDTH] = in_data;
               end
`ifdef DICE_CFG_CHECKSUM_EN
               ck_d = ck_q ^ in_data;
`endif
               if (last_word) begin
                  word_idx_d = '0;
`ifdef DICE_CFG_CHECKSUM_EN
                  stage_d = tile_full;
                  state_d = S_CHECK;
`else
                  commit_en  = 1'b1;
                  stage_d    = '0;
                  tile_idx_d = tile_idx_q + TIDX_W'(1);
                  if (last_tile) begin
                     state_d     = S_DONE;
                     cfg_valid_d = 1'b1;
                     done_d      = 1'b1;
                  end
`endif
               end else begin
                  word_idx_d = word_idx_q + WIDX_W'(1);
               end
            end
         end
`ifdef DICE_CFG_CHECKSUM_EN
         S_CHECK: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               stage_d = '0;
            end else if (accept) begin
               // Staged tile is committed only when the checksum word matches
               if (in_data == ck_q) begin
                  commit_en = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               tile_full  = stage_q;
               stage_d    = '0;
               ck_d       = '0;
               tile_idx_d = tile_idx_q + TIDX_W'(1);
               if (last_tile) begin
                  state_d     = S_DONE;
                  cfg_valid_d = ~err_d;
                  done_d      = 1'b1;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (commit_en) begin
         for (int unsigned t = 0; t < NUM_TILES; t++) begin
            if (tile_idx_q == TIDX_W'(t)) cfg_d[t*TILE_BITS +: TILE_BITS] = tile_full;
         end
      end

`ifdef DICE_CFG_CHECKSUM_EN
      in_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
      in_ready_d = (state_d == S_LOAD);
`endif
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         word_idx_q  <= '0;
         tile_idx_q  <= '0;
         stage_q     <= '0;
         cfg_q       <= '0;
         cfg_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         in_ready_q  <= 1'b0;
`ifdef DICE_CFG_CHECKSUM_EN
         err_q       <= 1'b0;
         ck_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         word_idx_q  <= word_idx_d;
         tile_idx_q  <= tile_idx_d;
         stage_q     <= stage_d;
         cfg_q       <= cfg_d;
         cfg_valid_q <= cfg_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         in_ready_q  <= in_ready_d;
`ifdef DICE_CFG_CHECKSUM_EN
         err_q       <= err_d;
         ck_q        <= ck_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign cgra_cfg  = cfg_q;
   assign cfg_valid = cfg_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef DICE_CFG_CHECKSUM_EN
   assign cfg_err   = err_q;
`else
   assign cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dice_cgra_cfg_loader.sv
// Directed, table-driven bench for dice_cgra_cfg_loader at default parameters.
// Streams word n = base + n; the checksum word is inserted when DICE_CFG_CHECKSUM_EN is defined.
module tb_dice_cgra_cfg_loader;

   localparam int TB  = 156;
   localparam int NT  = 16;
   localparam int WPT = 5;
`ifdef DICE_CFG_CHECKSUM_EN
   localparam int WPQ = WPT + 1;
`else
   localparam int WPQ = WPT;
`endif
   localparam int NQ  = NT * WPQ;

   logic              clk = 1'b0;
   logic              rst, start, abort, in_valid, in_ready;
   logic [31:0]       in_data;
   logic [TB*NT-1:0]  cgra_cfg;
   logic              cfg_valid, busy, done, cfg_err;

   int errors = 0;
   int checks = 0;
   logic [31:0] wq [$];

   typedef struct {
      int          tile;
      int          word;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [8];

   always #5 clk = ~clk;

   dice_cgra_cfg_loader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .cgra_cfg  (cgra_cfg),
      .cfg_valid (cfg_valid),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word k of tile t as seen in cgra_cfg; the top word is 28 bits wide
   function automatic logic [31:0] tw(input int t, input int k);
      logic [TB-1:0] f;
      f = cgra_cfg[t*TB +: TB];
      if (k == WPT - 1) return {4'b0, f[155:128]};
      return f[k*32 +: 32];
   endfunction

   function automatic logic tile_nz(input int t);
      logic [TB-1:0] f;
      f = cgra_cfg[t*TB +: TB];
      return |f;
   endfunction

   task automatic build(input logic [31:0] base, input bit last_ones, input int bad_tile);
      logic [31:0] d, x;
      wq.delete();
      for (int t = 0; t < NT; t++) begin
         x = '0;
         for (int k = 0; k < WPT; k++) begin
            d = base + 32'(t * WPT + k);
            if (last_ones && t == NT - 1 && k == WPT - 1) d = 32'hFFFF_FFFF;
            wq.push_back(d);
            x = x ^ d;
         end
`ifdef DICE_CFG_CHECKSUM_EN
         wq.push_back((t == bad_tile) ? (x ^ 32'h1) : x);
`else
         if (t == bad_tile) x = '0;
`endif
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offer queue entries [first, n); returns edges spent and whether done rose early
   task automatic stream(input int first, input int n, input bit toggle,
                         output int edges, output bit early_done);
      int idx;
      bit v, rdy;
      idx = first;
      edges = 0;
      early_done = 1'b0;
      while (idx < n && edges < 4000) begin
         v = toggle ? (edges % 2 == 0) : 1'b1;
         in_valid = v;
         in_data  = wq[idx];
         rdy      = in_ready;
         tick();
         edges++;
         if (v && rdy) idx++;
         if (done && idx < n) early_done = 1'b1;
      end
      in_valid = 1'b0;
      if (idx < n) chk("stream_timeout", 64'(idx), 64'(n));
   endtask

   initial begin
      int e;
      bit ed;
      vt[0] = '{0, 0, 32'd0};
      vt[1] = '{0, 4, 32'd4};
      vt[2] = '{1, 0, 32'd5};
      vt[3] = '{3, 2, 32'd17};
      vt[4] = '{7, 3, 32'd38};
      vt[5] = '{9, 1, 32'd46};
      vt[6] = '{15, 3, 32'd78};
      vt[7] = '{15, 4, 32'd79};

      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_outs", {58'b0, |cgra_cfg, cfg_valid, busy, done, in_ready, cfg_err}, 64'd0);

      // Full load, in_valid held high; start and abort together in IDLE
      build(32'd0, 1'b0, -1);
      abort = 1'b1;
      do_start();
      abort = 1'b0;
      chk("start_wins_abort", {62'b0, busy, in_ready}, 64'b11);
      stream(0, NQ, 1'b0, e, ed);
      chk("done_latency", 64'(e + 1), 64'(NQ + 1));
      chk("done_early", 64'(ed), 64'd0);
      chk("done_pulse", {61'b0, done, cfg_valid, cfg_err}, 64'b110);
      for (int i = 0; i < 8; i++)
         chk($sformatf("run1_t%0d_w%0d", vt[i].tile, vt[i].word), 64'(tw(vt[i].tile, vt[i].word)), 64'(vt[i].exp));
      tick();
      chk("after_done", {61'b0, done, busy, cfg_valid}, 64'b001);
      tick();
      chk("cfg_valid_hold", {63'b0, cfg_valid}, 64'd1);

      // Same stream with in_valid toggling 1-0-1
      do_start();
      chk("start_clears_valid", {63'b0, cfg_valid}, 64'd0);
      stream(0, NQ, 1'b1, e, ed);
      chk("toggle_latency", 64'(e), 64'(2 * NQ - 1));
      chk("toggle_done", {62'b0, done, cfg_valid}, 64'b11);
      for (int i = 0; i < 8; i++)
         chk($sformatf("run2_t%0d_w%0d", vt[i].tile, vt[i].word), 64'(tw(vt[i].tile, vt[i].word)), 64'(vt[i].exp));
      tick();

      // Abort after 12 words, then restart
      build(32'h100, 1'b0, -1);
      do_start();
      stream(0, 12, 1'b0, e, ed);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_outs", {60'b0, busy, cfg_valid, done, in_ready}, 64'd0);
      chk("abort_t0_w0", 64'(tw(0, 0)), 64'h100);
      chk("abort_t1_w4", 64'(tw(1, 4)), 64'h109);
      chk("abort_t2_empty", 64'(tile_nz(2)), 64'd0);
      tick();
      chk("abort_no_done", {62'b0, done, busy}, 64'd0);
      build(32'd0, 1'b0, -1);
      do_start();
      stream(0, NQ, 1'b0, e, ed);
      chk("restart_done", {62'b0, done, cfg_valid}, 64'b11);
      chk("restart_t5_w2", 64'(tw(5, 2)), 64'd27);
      tick();

      // Abort coinciding with the final word
      do_start();
      stream(0, NQ - 1, 1'b0, e, ed);
      in_valid = 1'b1;
      in_data  = wq[NQ-1];
      abort    = 1'b1;
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abort_last_outs", {61'b0, done, cfg_valid, busy}, 64'd0);
      chk("abort_last_t15", 64'(tile_nz(15)), 64'd0);
      chk("abort_last_t14", 64'(tw(14, 0)), 64'd70);
      tick();
      chk("abort_last_nodone", {63'b0, done}, 64'd0);

      // start pulsed mid-load is ignored; rst after 40 words clears everything
      build(32'h1000, 1'b0, -1);
      do_start();
      stream(0, 20, 1'b0, e, ed);
      start = 1'b1;
      tick();
      start = 1'b0;
      stream(20, 40, 1'b0, e, ed);
      chk("midload_start_ign", 64'(tw(1, 0)), 64'h1005);
      chk("midload_busy", {62'b0, busy, in_ready}, 64'b11);
      rst = 1'b1;
      start = 1'b1;
      abort = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      chk("rst_outs", {58'b0, |cgra_cfg, cfg_valid, busy, done, in_ready, cfg_err}, 64'd0);
      tick();
      chk("rst_idle", {62'b0, busy, in_ready}, 64'd0);

      // All-ones final word: only the low 28 bits land in tile 15
      build(32'd0, 1'b1, -1);
      do_start();
      stream(0, NQ, 1'b0, e, ed);
      chk("ones_t15_w4", 64'(tw(15, 4)), 64'h0FFF_FFFF);
      chk("ones_t15_w3", 64'(tw(15, 3)), 64'd78);
      chk("ones_valid", {62'b0, done, cfg_valid}, 64'b11);
      tick();

`ifdef DICE_CFG_CHECKSUM_EN
      // Corrupted checksum on tile 3
      build(32'd0, 1'b0, 3);
      do_start();
      stream(0, NQ, 1'b0, e, ed);
      chk("cks_done", {61'b0, done, cfg_valid, cfg_err}, 64'b101);
      chk("cks_t3_empty", 64'(tile_nz(3)), 64'd0);
      chk("cks_t4_w0", 64'(tw(4, 0)), 64'd20);
      chk("cks_t2_w1", 64'(tw(2, 1)), 64'd11);
      tick();
      chk("cks_sticky", {62'b0, cfg_err, done}, 64'b10);
`else
      chk("no_cks_err", {63'b0, cfg_err}, 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
